pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and return-stack stage that sits directly upstream of the control unit. It holds the instruction address and advances it, branches, calls or returns according to the control unit's `PCpp`, `JMP`, `call`, `ret` outputs. It owns a hardware return-address stack and accepts external interrupts, raising `CallInt` back to the control unit so that the interrupt entry is executed as a forced call.

## Interface
- `AW`, 16, width of the program address.
- `DEPTH`, 8, number of return-stack entries (power of two, at least 2).
- `INT_VECTOR`, 16'h0002, interrupt service entry address; truncated to `AW` bits.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `PCpp`  in  1  sequential-advance enable from the control unit.
- `JMP`  in  1  flag-qualified jump from the control unit.
- `call`  in  1  subroutine call from the control unit.
- `ret`  in  1  subroutine return from the control unit.
- `target`  in  AW  jump/call destination (instruction immediate).
- `interrupt`  in  1  level-sensitive interrupt request.
- `PC`  out  AW  current instruction address (registered).
- `CallInt`  out  1  one-cycle interrupt-entry pulse to the control unit.
- `in_isr`  out  1  high while the interrupt service routine runs.
- `sp`  out  $clog2(DEPTH)+1  return-stack occupancy, 0..DEPTH.
- `ovf`  out  1  sticky stack-overflow flag.
- `unf`  out  1  sticky stack-underflow flag.

## Operation
- Exactly one action is taken per rising edge. Priority, highest first: interrupt entry, `ret`, `call`, `JMP`, `PCpp`, hold.
- Interrupt entry is eligible only when all of the following hold: `interrupt`=1, `in_isr`=0, `sp`<DEPTH, and `ret`=`call`=`JMP`=0. An eligible entry performs these steps:
  - push PC+1;
  - set PC <= INT_VECTOR;
  - set `in_isr` <= 1;
  - record isr_sp <= `sp` (the value before the push);
  - set `CallInt` high for the following cycle.
- `ret` with `sp`>0: PC <= top of stack, `sp` decrements. If the new `sp` equals isr_sp while `in_isr`=1, then `in_isr` <= 0.
- `ret` with `sp`=0: `unf` <= 1, PC <= PC+1, `sp` unchanged.
- `call` with `sp`<DEPTH: push PC+1, PC <= `target`.
- `call` with `sp`=DEPTH: `ovf` <= 1, push discarded, PC <= `target` (the branch is still taken).
- `JMP`: PC <= `target`.
- `PCpp` alone: PC <= PC+1.
- No input asserted: PC holds.
- PC+1 is computed modulo 2^AW, so 2^AW-1 wraps to 0, and the wrapped value is what gets pushed.
- The stack is LIFO; the entry at index `sp`-1 is the top.
- `ovf` and `unf` are cleared only by `RST`.
- `interrupt` is a level input. While `in_isr`=1 it is masked and not latched. If it is still high after the ISR exit, it is re-accepted on the next eligible edge.

## Timing
- Reset values (asynchronous, immediate on `RST` assertion): `PC`=0, `CallInt`=0, `in_isr`=0, `sp`=0, `ovf`=0, `unf`=0, isr_sp=0. Stack contents are don't-care.
- A reset asserted mid-operation, including during a `CallInt` pulse, aborts everything immediately.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: the new `PC` is visible in the cycle after the edge that samples the command, so all control actions have 1-cycle latency.
- `CallInt` is high for exactly one cycle: the cycle immediately after the acceptance edge, which is the same cycle in which `PC`=INT_VECTOR first appears.
- The ISR exit `ret` and a re-accepted interrupt can never share an edge; re-entry happens at the earliest one cycle later.
- After the first cycle out of reset, `PC`=0 and the block advances only when `PCpp`=1.

## Test plan
- Sequential advance and wrap: with AW=16, reset, then hold `PCpp`=1 for 3 cycles -> PC goes 0, 1, 2, 3. Force PC to 16'hFFFF via `JMP`, `target`=FFFF, then apply `PCpp` -> PC=0000.
- Nested call/return: at PC=0x10, `call` `target`=0x40; at 0x40, `call` `target`=0x80; then `ret`, `ret` -> PC sequence 0x40, 0x80, 0x41, 0x11; `sp` sequence 1, 2, 1, 0; `ovf`=`unf`=0.
- Overflow and underflow: DEPTH=8; issue 9 `call`s -> `sp`=8, `ovf`=1, PC=last `target`. Then issue 9 `ret`s -> 8 pops, the 9th sets `unf`=1 with PC=PC+1 and `sp`=0.
- Interrupt entry and exit: at PC=0x20 with `PCpp`=1, raise `interrupt` -> next cycle PC=0x0002, `CallInt`=1 for exactly one cycle, `in_isr`=1, `sp`=1. Keep `interrupt` high during the ISR -> no re-entry. Issue `ret` -> PC=0x21, `in_isr`=0. One cycle later, since `interrupt` is still high, it is re-accepted with PC=0x0002.
- Priority and deferral: assert `interrupt` and `JMP` `target`=0x30 on the same edge -> PC=0x30 and `CallInt`=0. The interrupt is taken on the next plain `PCpp` edge.
- Asynchronous reset: assert `RST` mid-ISR, in the same cycle `CallInt`=1 -> all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//   Program counter with a hardware return-address stack and interrupt entry.
//   One action is taken per rising edge. Priority, highest first:
//   interrupt entry, ret, call, JMP, PCpp, hold.
//
// Ports
//   CLK        in   1         system clock, rising-edge active
//   RST        in   1         asynchronous active-high reset
//   PCpp       in   1         sequential advance request
//   JMP        in   1         jump to target
//   call       in   1         push PC+1 and jump to target
//   ret        in   1         pop return address into PC
//   target     in   AW        jump/call destination
//   interrupt  in   1         level-sensitive interrupt request
//   PC         out  AW        current instruction address
//   CallInt    out  1         one-cycle interrupt-entry pulse
//   in_isr     out  1         interrupt service routine active
//   sp         out  SPW       return-stack occupancy, 0..DEPTH
//   ovf        out  1         sticky overflow flag (call on a full stack)
//   unf        out  1         sticky underflow flag (ret on an empty stack)
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int              AW         = 16,
  parameter int              DEPTH      = 8,
  parameter logic [AW-1:0]   INT_VECTOR = AW'(16'h0002)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PCpp,
  input  logic                       JMP,
  input  logic                       call,
  input  logic                       ret,
  input  logic [AW-1:0]              target,
  input  logic                       interrupt,
  output logic [AW-1:0]              PC,
  output logic                       CallInt,
  output logic                       in_isr,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       ovf,
  output logic                       unf
);

  localparam int              IW      = $clog2(DEPTH);
  localparam int              SPW     = IW + 1;
  localparam logic [SPW-1:0]  SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0]  SP_ONE  = SPW'(1);

  // One selected action per edge
  typedef enum logic [2:0] {
    ACT_HOLD = 3'd0,
    ACT_INC  = 3'd1,
    ACT_JMP  = 3'd2,
    ACT_CALL = 3'd3,
    ACT_RET  = 3'd4,
    ACT_INT  = 3'd5
  } act_e;

  logic [AW-1:0]   r_pc;
  logic            r_callint;
  logic            r_in_isr;
  logic [SPW-1:0]  r_sp;
  logic [SPW-1:0]  r_isr_sp;
  logic            r_ovf;
  logic            r_unf;
  logic [AW-1:0]   r_stack [DEPTH];

  act_e            w_act;
  logic [AW-1:0]   w_pc_inc;
  logic [SPW-1:0]  w_sp_dec;
  logic [AW-1:0]   w_top;
  logic            w_full;
  logic            w_empty;
  logic            w_int_ok;

  logic [AW-1:0]   w_pc_nxt;
  logic [SPW-1:0]  w_sp_nxt;
  logic [SPW-1:0]  w_isr_sp_nxt;
  logic            w_isr_nxt;
  logic            w_callint_nxt;
  logic            w_push;
  logic            w_ovf_set;
  logic            w_unf_set;

  assign w_pc_inc = r_pc + AW'(1);          // wraps modulo 2^AW
  assign w_sp_dec = r_sp - SP_ONE;
  assign w_full   = (r_sp == SP_FULL);
  assign w_empty  = (r_sp == '0);
  assign w_top    = r_stack[w_sp_dec[IW-1:0]];

  // Interrupt is masked inside the ISR, on a full stack, and whenever the
  // control unit issues a flow change this edge (it is deferred, not lost,
  // because the request is a level).
  assign w_int_ok = interrupt & ~r_in_isr & ~w_full & ~ret & ~call & ~JMP;

  // Action select by fixed priority
  always_comb begin
    w_act = ACT_HOLD;
    if (w_int_ok) begin
      w_act = ACT_INT;
    end else if (ret) begin
      w_act = ACT_RET;
    end else if (call) begin
      w_act = ACT_CALL;
    end else if (JMP) begin
      w_act = ACT_JMP;
    end else if (PCpp) begin
      w_act = ACT_INC;
    end else begin
      w_act = ACT_HOLD;
    end
  end

  // Next-state computation for PC, stack pointer and ISR tracking
  always_comb begin
    w_pc_nxt      = r_pc;
    w_sp_nxt      = r_sp;
    w_isr_nxt     = r_in_isr;
    w_isr_sp_nxt  = r_isr_sp;
    w_callint_nxt = 1'b0;
    w_push        = 1'b0;
    w_ovf_set     = 1'b0;
    w_unf_set     = 1'b0;
    case (w_act)
      ACT_INT: begin
        w_push        = 1'b1;
        w_pc_nxt      = INT_VECTOR;
        w_sp_nxt      = r_sp + SP_ONE;
        w_isr_nxt     = 1'b1;
        w_isr_sp_nxt  = r_sp;
        w_callint_nxt = 1'b1;
      end
      ACT_RET: begin
        if (!w_empty) begin
          w_pc_nxt = w_top;
          w_sp_nxt = w_sp_dec;
          // Popping back to the depth recorded at entry ends the ISR
          if (r_in_isr && (w_sp_dec == r_isr_sp)) begin
            w_isr_nxt = 1'b0;
          end else begin
            w_isr_nxt = r_in_isr;
          end
        end else begin
          w_unf_set = 1'b1;
          w_pc_nxt  = w_pc_inc;
        end
      end
      ACT_CALL: begin
        w_pc_nxt = target;
        if (!w_full) begin
          w_push   = 1'b1;
          w_sp_nxt = r_sp + SP_ONE;
        end else begin
          w_ovf_set = 1'b1;
        end
      end
      ACT_JMP:  w_pc_nxt = target;
      ACT_INC:  w_pc_nxt = w_pc_inc;
      ACT_HOLD: w_pc_nxt = r_pc;
      default:  w_pc_nxt = r_pc;
    endcase
  end

  // Architectural state registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc      <= '0;
      r_callint <= 1'b0;
      r_in_isr  <= 1'b0;
      r_sp      <= '0;
      r_isr_sp  <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_callint <= w_callint_nxt;
      r_in_isr  <= w_isr_nxt;
      r_sp      <= w_sp_nxt;
      r_isr_sp  <= w_isr_sp_nxt;
      r_ovf     <= r_ovf | w_ovf_set;
      r_unf     <= r_unf | w_unf_set;
    end
  end

  // Return-stack storage; contents are don't-care after reset
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_stack[r_sp[IW-1:0]] <= w_pc_inc;
    end
  end

  assign PC      = r_pc;
  assign CallInt = r_callint;
  assign in_isr  = r_in_isr;
  assign sp      = r_sp;
  assign ovf     = r_ovf;
  assign unf     = r_unf;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//   Table of {command, expected outputs} vectors applied one per clock edge.
//   Expected records are queued when a vector is driven and popped and
//   compared on the following falling edge. Hand-written sequences cover
//   the asynchronous reset during a CallInt pulse.
// ---------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        pcpp;
  logic        jmp;
  logic        call_i;
  logic        ret_i;
  logic [15:0] target;
  logic        irq;
  logic [15:0] pc;
  logic        callint;
  logic        in_isr;
  logic [3:0]  sp;
  logic        ovf;
  logic        unf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic        pcpp;
    logic        jmp;
    logic        cl;
    logic        rt;
    logic        irq;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic [3:0]  e_sp;
    logic        e_ci;
    logic        e_isr;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  pc_unit #(.AW(16), .DEPTH(8), .INT_VECTOR(16'h0002)) dut (
    .CLK(clk), .RST(rst), .PCpp(pcpp), .JMP(jmp), .call(call_i), .ret(ret_i),
    .target(target), .interrupt(irq), .PC(pc), .CallInt(callint),
    .in_isr(in_isr), .sp(sp), .ovf(ovf), .unf(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, id, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic j, input logic c, input logic r,
                     input logic i, input logic [15:0] t, input logic [15:0] epc,
                     input logic [3:0] esp, input logic eci, input logic eisr,
                     input logic eovf, input logic eunf);
    vec_t v;
    v.id = vecs.size();
    v.pcpp = p; v.jmp = j; v.cl = c; v.rt = r; v.irq = i; v.tgt = t;
    v.e_pc = epc; v.e_sp = esp; v.e_ci = eci; v.e_isr = eisr;
    v.e_ovf = eovf; v.e_unf = eunf;
    vecs.push_back(v);
  endtask

  task automatic check_outputs();
    vec_t e;
    if (exp_q.size() == 0) begin
      chk("queue_empty", -1, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("pc",      e.id, {16'd0, pc},      {16'd0, e.e_pc});
      chk("sp",      e.id, {28'd0, sp},      {28'd0, e.e_sp});
      chk("callint", e.id, {31'd0, callint}, {31'd0, e.e_ci});
      chk("in_isr",  e.id, {31'd0, in_isr},  {31'd0, e.e_isr});
      chk("ovf",     e.id, {31'd0, ovf},     {31'd0, e.e_ovf});
      chk("unf",     e.id, {31'd0, unf},     {31'd0, e.e_unf});
    end
  endtask

  // Drive on the falling edge, sample on the next falling edge
  task automatic apply(input vec_t v);
    pcpp = v.pcpp; jmp = v.jmp; call_i = v.cl; ret_i = v.rt;
    irq = v.irq; target = v.tgt;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset(input int id);
    chk("rst_pc",      id, {16'd0, pc},      32'd0);
    chk("rst_sp",      id, {28'd0, sp},      32'd0);
    chk("rst_callint", id, {31'd0, callint}, 32'd0);
    chk("rst_in_isr",  id, {31'd0, in_isr},  32'd0);
    chk("rst_ovf",     id, {31'd0, ovf},     32'd0);
    chk("rst_unf",     id, {31'd0, unf},     32'd0);
  endtask

  task automatic idle_inputs();
    pcpp = 1'b0; jmp = 1'b0; call_i = 1'b0; ret_i = 1'b0;
    irq = 1'b0; target = 16'h0000;
  endtask

  initial begin
    vec_t v;
    idle_inputs();
    rst = 1'b0;

    // Args: PCpp JMP call ret irq target | PC sp CallInt in_isr ovf unf
    // Sequential advance and wrap
    add(1,0,0,0,0,16'h0000, 16'h0001,4'd0,0,0,0,0);
    add(1,0,0,0,0,16'h0000, 16'h0002,4'd0,0,0,0,0);
    add(1,0,0,0,0,16'h0000, 16'h0003,4'd0,0,0,0,0);
    add(0,1,0,0,0,16'hFFFF, 16'hFFFF,4'd0,0,0,0,0);
    add(1,0,0,0,0,16'h0000, 16'h0000,4'd0,0,0,0,0);
    add(0,0,0,0,0,16'h1234, 16'h0000,4'd0,0,0,0,0);   // hold
    // Nested call / return
    add(0,1,0,0,0,16'h0010, 16'h0010,4'd0,0,0,0,0);
    add(0,0,1,0,0,16'h0040, 16'h0040,4'd1,0,0,0,0);
    add(0,0,1,0,0,16'h0080, 16'h0080,4'd2,0,0,0,0);
    add(0,0,0,1,0,16'h0000, 16'h0041,4'd1,0,0,0,0);
    add(0,0,0,1,0,16'h0000, 16'h0011,4'd0,0,0,0,0);
    // Call from FFFF pushes the wrapped return address 0000
    add(0,1,0,0,0,16'hFFFF, 16'hFFFF,4'd0,0,0,0,0);
    add(0,0,1,0,0,16'h0050, 16'h0050,4'd1,0,0,0,0);
    add(0,0,0,1,0,16'h0000, 16'h0000,4'd0,0,0,0,0);
    // Command priority: call over JMP/PCpp, ret over call
    add(1,1,1,0,0,16'h0060, 16'h0060,4'd1,0,0,0,0);
    add(1,0,1,1,0,16'h0070, 16'h0001,4'd0,0,0,0,0);
    // Interrupt entry, masking in ISR, nested call, exit, re-entry
    add(0,1,0,0,0,16'h0020, 16'h0020,4'd0,0,0,0,0);
    add(1,0,0,0,1,16'h0000, 16'h0002,4'd1,1,1,0,0);
    add(1,0,0,0,1,16'h0000, 16'h0003,4'd1,0,1,0,0);
    add(0,0,1,0,1,16'h0090, 16'h0090,4'd2,0,1,0,0);
    add(0,0,0,1,1,16'h0000, 16'h0004,4'd1,0,1,0,0);
    add(0,0,0,1,1,16'h0000, 16'h0021,4'd0,0,0,0,0);
    add(0,0,0,0,1,16'h0000, 16'h0002,4'd1,1,1,0,0);
    add(0,0,0,1,0,16'h0000, 16'h0022,4'd0,0,0,0,0);
    // JMP defers the interrupt to the next plain PCpp edge
    add(0,1,0,0,1,16'h0030, 16'h0030,4'd0,0,0,0,0);
    add(1,0,0,0,1,16'h0000, 16'h0002,4'd1,1,1,0,0);
    add(0,0,0,1,0,16'h0000, 16'h0031,4'd0,0,0,0,0);
    // Nine calls: the ninth overflows but still branches
    for (int k = 0; k < 9; k++) begin
      add(0,0,1,0,0,16'h0100 + 16'(k), 16'h0100 + 16'(k),
          (k < 8) ? 4'(k + 1) : 4'd8, 0,0, (k == 8), 0);
    end
    // Full stack blocks interrupt entry; PCpp proceeds
    add(1,0,0,0,1,16'h0000, 16'h0109,4'd8,0,0,1,0);
    // Nine returns: eight pops, then underflow
    for (int j = 0; j < 9; j++) begin
      if (j < 8) begin
        add(0,0,0,1,0,16'h0000, (7 - j == 0) ? 16'h0032 : 16'h0100 + 16'(7 - j),
            4'(7 - j), 0,0,1,0);
      end else begin
        add(0,0,0,1,0,16'h0000, 16'h0033,4'd0,0,0,1,1);
      end
    end
    // Take an interrupt so CallInt is high for the reset test
    add(1,0,0,0,1,16'h0000, 16'h0002,4'd1,1,1,1,1);

    // Asynchronous reset from power-up
    #2 rst = 1'b1;
    #1 check_reset(1000);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < vecs.size(); n++) begin
      apply(vecs[n]);
    end

    // Reset mid-cycle while CallInt is high: outputs clear with no clock edge
    chk("pre_rst_callint", 1001, {31'd0, callint}, 32'd1);
    idle_inputs();
    #2 rst = 1'b1;
    #1 check_reset(1002);
    @(posedge clk);
    #1 check_reset(1003);
    @(negedge clk);
    rst = 1'b0;

    // After reset: holds at 0 without PCpp, then advances
    v = vecs[0];
    v.id = 2000; v.pcpp = 1'b0; v.tgt = 16'h0000; v.e_pc = 16'h0000;
    apply(v);
    v.id = 2001; v.pcpp = 1'b1; v.e_pc = 16'h0001;
    apply(v);
    chk("queue_drained", 2002, 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
